sincos_arbiter: RTL and testbench

- Shares one `sincos_block` (3-cycle sin/cos datapath with no valid/enable) between NUM_REQ Box-Muller lanes.
- Round-robin arbitration of u1 requests; drives `sc_u1`.
- Tracks in-flight samples with a shift-register valid/ID pipe matched to the datapath latency.
- Captures g0/g1 into a credit-protected response FIFO with valid/ready backpressure, so no result is ever dropped.

---
 rtl/sincos_pkg.sv | 22 ++
 rtl/sincos_rsp_fifo.sv | 56 +++++
 rtl/sincos_arbiter.sv | 125 ++++++++++++
 tb/tb_sincos_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
// rtl/sincos_pkg.sv - shared constants, pipe-entry type and clog2 helper for the sincos arbiter
package sincos_pkg;

    localparam int SINCOS_LAT = 3;
    localparam int U1_W       = 16;
    localparam int G_W        = 16;
    localparam int ID_MAX_W   = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // One slot of the in-flight tracker; id is sized for the largest lane count.
    typedef struct packed {
        logic                v;
        logic [ID_MAX_W-1:0] id;
    } pipe_entry_t;

endpackage

// File: rtl/sincos_rsp_fifo.sv
// rtl/sincos_rsp_fifo.sv - first-word-fall-through sync FIFO with occupancy count
module sincos_rsp_fifo
    import sincos_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CW'(DEPTH));
    assign do_push    = push && !full;
    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/sincos_arbiter.sv
// rtl/sincos_arbiter.sv - shares one sincos datapath between lanes; SINCOS_ARB_STRICT_PRIO_EN selects fixed priority
module sincos_arbiter
    import sincos_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SINCOS_LAT = sincos_pkg::SINCOS_LAT,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [U1_W*NUM_REQ-1:0] req_u1,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [U1_W-1:0]         sc_u1,
    input  logic [G_W-1:0]          sc_g0,
    input  logic [G_W-1:0]          sc_g1,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [G_W-1:0]          rsp_g0,
    output logic [G_W-1:0]          rsp_g1,
    output logic                    busy
);

    localparam int PIPE_N  = SINCOS_LAT + 1;
    localparam int OCC_W   = clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = ID_W + 2 * G_W;

    pipe_entry_t      pipe [PIPE_N];
    logic [OCC_W-1:0] occ;
    logic             can_issue;
    logic             hs;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  idx;
    int               inflight;
    int               pos;
    logic [U1_W-1:0]  lane_u1 [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_u1[i] = req_u1[U1_W*i +: U1_W];
    end

    always_comb begin
        inflight = 0;
        for (int s = 0; s < PIPE_N; s++) inflight = inflight + int'(pipe[s].v);
    end

    // Credits count slots already reserved downstream; a pop only frees one next cycle.
    assign can_issue = reset && en && ((int'(occ) + inflight) < FIFO_DEPTH);

`ifndef SINCOS_ARB_STRICT_PRIO_EN
    logic [ID_W-1:0] rr_ptr;
`endif

    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        hs        = 1'b0;
        idx       = '0;
        pos       = 0;
        for (int o = 0; o < NUM_REQ; o++) begin
`ifdef SINCOS_ARB_STRICT_PRIO_EN
            pos = o;
`else
            pos = (int'(rr_ptr) + o) % NUM_REQ;
`endif
            idx = ID_W'(pos);
            if (can_issue && !hs && req_valid[idx]) begin
                req_ready[idx] = 1'b1;
                gnt_id         = idx;
                hs             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc_u1 <= '0;
            for (int s = 0; s < PIPE_N; s++) pipe[s] <= '0;
`ifndef SINCOS_ARB_STRICT_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            if (hs) sc_u1 <= lane_u1[gnt_id];
            pipe[0].v  <= hs;
            pipe[0].id <= ID_MAX_W'(gnt_id);
            for (int s = 1; s < PIPE_N; s++) pipe[s] <= pipe[s-1];
`ifndef SINCOS_ARB_STRICT_PRIO_EN
            if (hs) rr_ptr <= (int'(gnt_id) + 1 == NUM_REQ) ? '0 : gnt_id + 1'b1;
`endif
        end
    end

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] fifo_head;
    logic               unused_id;

    // The last pipe stage lines up with the datapath output for the same sample.
    assign push      = pipe[PIPE_N-1].v;
    assign push_data = {pipe[PIPE_N-1].id[ID_W-1:0], sc_g0, sc_g1};
    assign pop       = rsp_valid && rsp_ready;
    assign unused_id = ^pipe[PIPE_N-1].id;

    sincos_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (rsp_valid),
        .head_data  (fifo_head),
        .count      (occ)
    );

    assign {rsp_id, rsp_g0, rsp_g1} = fifo_head;
    assign busy = (inflight != 0) || (occ != '0);

endmodule

// File: tb/tb_sincos_arbiter.sv
// tb/tb_sincos_arbiter.sv - scoreboard bench for sincos_arbiter with a behavioural sincos_block
module tb_sincos_arbiter;
    import sincos_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int ID_W       = 1;
    localparam int FIFO_DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   en = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [16*NUM_REQ-1:0]  req_u1 = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [15:0]            sc_u1, sc_g0, sc_g1, rsp_g0, rsp_g1;
    logic                   rsp_valid, busy;
    logic                   rsp_ready = 1'b0;
    logic [ID_W-1:0]        rsp_id;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     g0;
        logic [15:0]     g1;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   rsp_count = 0;
    int   grant_count [NUM_REQ] = '{default: 0};
    int   tb_rr = 0;
    logic [15:0] u = 16'h1000;

    sincos_arbiter #(
        .NUM_REQ(NUM_REQ), .SINCOS_LAT(3), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_u1(req_u1),
        .req_ready(req_ready), .sc_u1(sc_u1), .sc_g0(sc_g0), .sc_g1(sc_g1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_g0(rsp_g0), .rsp_g1(rsp_g1), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdl_g0(input logic [15:0] x);
        return x ^ 16'h5a5a;
    endfunction

    function automatic logic [15:0] mdl_g1(input logic [15:0] x);
        return {x[7:0], x[15:8]} + 16'h0101;
    endfunction

    // Three-register datapath with no valid, as the real block behaves.
    logic [15:0] m0 [3] = '{default: '0};
    logic [15:0] m1 [3] = '{default: '0};
    always @(posedge clk) begin
        m0[0] <= mdl_g0(sc_u1); m0[1] <= m0[0]; m0[2] <= m0[1];
        m1[0] <= mdl_g1(sc_u1); m1[1] <= m1[0]; m1[2] <= m1[1];
    end
    assign sc_g0 = m0[2];
    assign sc_g1 = m1[2];

    function automatic logic [15:0] lane_u(input int i);
        logic [16*NUM_REQ-1:0] v;
        v = req_u1;
        return v[16*i +: 16];
    endfunction

    function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int o = 0; o < NUM_REQ; o++)
            if (v[(ptr + o) % NUM_REQ]) return (ptr + o) % NUM_REQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        int   want;
        exp_t e;
        exp_t got;
        if (reset) begin
            if (req_ready != '0) begin
                checks++;
                if (((req_ready & (req_ready - 1'b1)) != '0) || ((req_ready & ~req_valid) != '0)) begin
                    errors++;
                    $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
`ifdef SINCOS_ARB_STRICT_PRIO_EN
                    want = exp_grant(req_valid, 0);
`else
                    want = exp_grant(req_valid, tb_rr);
`endif
                    checks++;
                    if (i != want) begin
                        errors++;
                        $display("FAIL grant_lane: got lane %0d, required lane %0d", i, want);
                    end
                    e.id = ID_W'(i);
                    e.g0 = mdl_g0(lane_u(i));
                    e.g1 = mdl_g1(lane_u(i));
                    sb.push_back(e);
                    grant_count[i]++;
                    tb_rr = (i + 1) % NUM_REQ;
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                got = {rsp_id, rsp_g0, rsp_g1};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %h, required no response", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rsp_data: got %h, required %h", got, e);
                    end
                end
                rsp_count++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [15:0] val);
        req_u1[16*i +: 16] = val;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, required 0 and 0", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
        set_lane(0, 16'h1234); set_lane(1, 16'h5678);
        repeat (3) step();
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b, required 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %h, required 0", rsp_id); end
        checks++; if (rsp_g0 !== 16'h0) begin errors++; $display("FAIL reset_rsp_g0: got %h, required 0", rsp_g0); end
        checks++; if (rsp_g1 !== 16'h0) begin errors++; $display("FAIL reset_rsp_g1: got %h, required 0", rsp_g1); end
        checks++; if (sc_u1 !== 16'h0) begin errors++; $display("FAIL reset_sc_u1: got %h, required 0", sc_u1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        step();
        reset = 1'b1; req_valid = '0; en = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        step();
        en = 1'b1; rsp_ready = 1'b1; req_valid = 2'b01; set_lane(0, 16'h0000);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b, required 01", req_ready); end
        step();
        req_valid = '0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = c; break; end
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL single_latency: got %0d cycles, required 5", lat); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %h, required 0", rsp_id); end
        checks++; if (rsp_g0 !== mdl_g0(16'h0000) || rsp_g1 !== mdl_g1(16'h0000)) begin
            errors++; $display("FAIL single_data: got %h/%h, required %h/%h", rsp_g0, rsp_g1, mdl_g0(16'h0), mdl_g1(16'h0));
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int g [16];
        int prev;
        logic bad;
        wait_idle();
        u = 16'h1000;
        for (int c = 0; c < 16; c++) begin
            step();
            en = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
            set_lane(0, u); set_lane(1, u);
            @(negedge clk);
            g[c] = req_ready[0] ? 0 : (req_ready[1] ? 1 : -1);
            if (req_ready != '0) u++;
        end
        step();
        req_valid = '0;
        checks++; if (g[0] < 0 || g[1] < 0 || g[2] < 0 || g[3] < 0) begin
            errors++; $display("FAIL b2b_fill: got %0d %0d %0d %0d, required grants in cycles 0-3", g[0], g[1], g[2], g[3]);
        end
        checks++; if (g[4] != -1 || g[5] != -1) begin
            errors++; $display("FAIL b2b_credit_stall: got %0d %0d, required -1 -1", g[4], g[5]);
        end
        checks++; if (g[6] < 0) begin errors++; $display("FAIL b2b_credit_resume: got %0d, required a grant", g[6]); end
        bad = 1'b0; prev = -1;
        for (int c = 0; c < 16; c++) begin
            if (g[c] >= 0) begin
`ifdef SINCOS_ARB_STRICT_PRIO_EN
                if (g[c] != 0) bad = 1'b1;
`else
                if (g[c] == prev) bad = 1'b1;
`endif
                prev = g[c];
            end
        end
        checks++; if (bad) begin errors++; $display("FAIL b2b_pattern: got lane %0d repeated, required expected lane order", prev); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int ng, base;
        logic resumed;
        logic [15:0] hold_g0;
        logic [ID_W-1:0] hold_id;
        wait_idle();
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            en = 1'b1; rsp_ready = 1'b0; req_valid = 2'b10; set_lane(1, u);
            @(negedge clk);
            if (req_ready[1]) begin ng++; u++; end
        end
        checks++; if (ng != FIFO_DEPTH) begin errors++; $display("FAIL bp_grants: got %0d, required %0d", ng, FIFO_DEPTH); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready_low: got %b, required 00", req_ready); end
        hold_g0 = rsp_g0; hold_id = rsp_id;
        step();
        @(negedge clk);
        checks++; if (!rsp_valid || rsp_g0 !== hold_g0 || rsp_id !== hold_id) begin
            errors++; $display("FAIL bp_hold: got v=%b g0=%h id=%h, required v=1 g0=%h id=%h", rsp_valid, rsp_g0, rsp_id, hold_g0, hold_id);
        end
        step();
        base = rsp_count; resumed = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin resumed = 1'b1; u++; end
            set_lane(1, u);
            step();
            set_lane(1, u);
        end
        req_valid = '0;
        checks++; if (rsp_count - base < FIFO_DEPTH) begin errors++; $display("FAIL bp_drain: got %0d, required >= %0d", rsp_count - base, FIFO_DEPTH); end
        checks++; if (!resumed) begin errors++; $display("FAIL bp_resume: got no grant, required a grant"); end
        wait_idle();
    endtask

    task automatic test_en();
        int base;
        logic bad, busy_start, busy_end;
        wait_idle();
        for (int c = 0; c < 3; c++) begin
            step();
            en = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11; set_lane(0, u); set_lane(1, u);
            @(negedge clk);
            if (req_ready != '0) u++;
        end
        bad = 1'b0; base = 0; busy_start = 1'b0; busy_end = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0) base = rsp_count;
            en = 1'b0;
            @(negedge clk);
            if (req_ready !== 2'b00) bad = 1'b1;
            if (c == 0) busy_start = busy;
            busy_end = busy;
        end
        step();
        checks++; if (bad) begin errors++; $display("FAIL en_no_grant: got a grant, required none"); end
        checks++; if (rsp_count - base != 3) begin errors++; $display("FAIL en_drain: got %0d, required 3", rsp_count - base); end
        checks++; if (busy_start !== 1'b1 || busy_end !== 1'b0) begin
            errors++; $display("FAIL en_busy: got start=%b end=%b, required 1 0", busy_start, busy_end);
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (req_ready == 2'b00) begin errors++; $display("FAIL en_resume: got %b, required a grant", req_ready); end
        step();
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic bad;
        wait_idle();
        for (int c = 0; c < 6; c++) begin
            step();
            en = 1'b1; rsp_ready = 1'b0; req_valid = 2'b01; set_lane(0, u);
            @(negedge clk);
            if (req_ready[0]) u++;
        end
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: got v=%b busy=%b, required 1 1", rsp_valid, busy);
        end
        step();
        reset = 1'b0; sb.delete(); tb_rr = 0; rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_async: got v=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        step();
        step();
        reset = 1'b1; req_valid = '0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rmid_quiet: got rsp_valid=1, required 0 for 8 cycles"); end
        step();
        req_valid = 2'b11; set_lane(0, u); set_lane(1, u);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_rr_restart: got %b, required 01", req_ready); end
        step();
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_priority();
        int b0, b1, d0, d1, e1;
        wait_idle();
        step();
        b0 = grant_count[0]; b1 = grant_count[1];
        en = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            set_lane(0, 16'h2000 + 16'(c)); set_lane(1, 16'h3000 + 16'(c));
            @(negedge clk);
            step();
        end
        d0 = grant_count[0] - b0; d1 = grant_count[1] - b1; e1 = grant_count[1];
        req_valid = 2'b10;
        for (int c = 0; c < 12; c++) begin
            set_lane(1, 16'h4000 + 16'(c));
            @(negedge clk);
            step();
        end
        req_valid = '0;
`ifdef SINCOS_ARB_STRICT_PRIO_EN
        checks++; if (d0 == 0 || d1 != 0) begin errors++; $display("FAIL prio_starve: got lane0=%0d lane1=%0d, required >0 and 0", d0, d1); end
`else
        checks++; if (d0 == 0 || d1 == 0 || d0 - d1 > 1 || d1 - d0 > 1) begin
            errors++; $display("FAIL rr_fair: got lane0=%0d lane1=%0d, required balanced", d0, d1);
        end
`endif
        checks++; if (grant_count[1] - e1 == 0) begin errors++; $display("FAIL prio_lane1_alone: got 0 grants, required > 0"); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_en();
        test_reset_mid();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
